// File: rtl/oam_scanner.sv
// oam_scanner: mode-2 OAM search sequencer.
//
// On each rising entry into PPU mode 2 this block walks all OAM entries. Each
// entry takes two enabled ticks. In phase 0 the entry address is presented.
// In phase 1 the sprite Y byte returned on oam_rdata is compared against the
// current line. Up to MAX_LINE_SP hits are streamed to the sprite fetcher as
// {sprite number, row within sprite}, in ascending entry order.
//
// Ports:
//   clk                 system clock
//   reset_n             synchronous active-low reset
//   slow_clk_en         dot-rate enable; all state advances only when high
//   lcd_enable          LCDC.7; low forces IDLE
//   mode                PPU mode (2 = OAM scan)
//   ly                  current line number
//   sp_8x16             sprite height select (0: 8 rows, 1: 16 rows)
//   oam_rdata           OAM read data (sprite Y during phase 1)
//   oam_scan_addr       OAM byte address {entry, 2'b00}, 0 outside SCAN
//   oam_scan_sp_num     entry number of the current hit
//   oam_scan_fine_y     row within sprite of the current hit
//   line_sp_list_write  hit strobe, level-valid for the whole phase-1 tick
//   scan_count          hits accepted this line
//   scan_done           high while in DONE
module oam_scanner #(
   parameter int unsigned MAX_LINE_SP = 10,
   parameter int unsigned OAM_ENTRIES = 40
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       slow_clk_en,
   input  logic       lcd_enable,
   input  logic [1:0] mode,
   input  logic [7:0] ly,
   input  logic       sp_8x16,
   input  logic [7:0] oam_rdata,
   output logic [7:0] oam_scan_addr,
   output logic [5:0] oam_scan_sp_num,
   output logic [3:0] oam_scan_fine_y,
   output logic       line_sp_list_write,
   output logic [3:0] scan_count,
   output logic       scan_done
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StScan = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   localparam logic [3:0] MaxCount  = 4'(MAX_LINE_SP);
   localparam logic [5:0] LastEntry = 6'(OAM_ENTRIES - 1);

   logic [1:0] state_q, state_d;
   logic [5:0] entry_q, entry_d;
   logic       phase_q, phase_d;
   logic [3:0] count_q, count_d;
   logic [1:0] prev_mode_q;

   logic [7:0] diff;
   logic       hit;
   logic       in_scan;
   logic       mode2;
   logic       write;

   // Row within the sprite; wraps modulo 256 so sprites below the line miss.
   always_comb begin
      diff    = ly + 8'd16 - oam_rdata;
      hit     = sp_8x16 ? (diff < 8'd16) : (diff < 8'd8);
      in_scan = (state_q == StScan);
      mode2   = (mode == 2'd2);
      // Gated by mode/lcd_enable so an aborting tick never emits a strobe.
      write   = in_scan & phase_q & hit & (count_q < MaxCount) & mode2 & lcd_enable;
   end

   always_comb begin
      state_d = state_q;
      entry_d = entry_q;
      phase_d = phase_q;
      count_d = count_q;
      case (state_q)
         StIdle: begin
            if (lcd_enable && mode2 && (prev_mode_q != 2'd2)) begin
               state_d = StScan;
               entry_d = 6'd0;
               phase_d = 1'b0;
               count_d = 4'd0;
            end
         end
         StScan: begin
            if (!lcd_enable || !mode2) begin
               state_d = StIdle;
            end else if (!phase_q) begin
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               if (write) begin
                  count_d = count_q + 4'd1;
               end
               if (entry_q == LastEntry) begin
                  state_d = StDone;
               end else begin
                  entry_d = entry_q + 6'd1;
               end
            end
         end
         StDone: begin
            if (!lcd_enable || !mode2) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         entry_q     <= 6'd0;
         phase_q     <= 1'b0;
         count_q     <= 4'd0;
         // Treat reset as already inside mode 2 so a reset during a line does
         // not restart the scan; only a genuine rising entry starts one.
         prev_mode_q <= 2'd2;
      end else if (slow_clk_en) begin
         state_q     <= state_d;
         entry_q     <= entry_d;
         phase_q     <= phase_d;
         count_q     <= count_d;
         prev_mode_q <= mode;
      end
   end

   always_comb begin
      oam_scan_addr      = in_scan ? {entry_q, 2'b00} : 8'd0;
      oam_scan_sp_num    = in_scan ? entry_q : 6'd0;
      oam_scan_fine_y    = in_scan ? diff[3:0] : 4'd0;
      line_sp_list_write = write;
      scan_count         = count_q;
      scan_done          = (state_q == StDone);
   end

endmodule
